// File: rtl/axi4_lite_2to1_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter; one whole transaction in flight, round-robin grant.
// Optional macro ARB_FIXED_PRIORITY_EN: M0 always wins simultaneous requests.
module axi4_lite_2to1_arbiter #(
  parameter int unsigned  p_ADDRESS_WIDTH = 2,
  parameter int unsigned  p_DATA_WIDTH    = 8,
  localparam int unsigned lp_STROBE_WIDTH = (p_DATA_WIDTH >= 8) ? p_DATA_WIDTH / 8 : 1
) (
  input  logic                       i_ACLK,
  input  logic                       i_ARESETN,
  // master 0
  input  logic [p_ADDRESS_WIDTH-1:0] i_M0_AWADDR,
  input  logic                       i_M0_AWPROT,
  input  logic                       i_M0_AWVALID,
  output logic                       o_M0_AWREADY,
  input  logic [p_DATA_WIDTH-1:0]    i_M0_WDATA,
  input  logic [lp_STROBE_WIDTH-1:0] i_M0_WSTRB,
  input  logic                       i_M0_WVALID,
  output logic                       o_M0_WREADY,
  output logic [1:0]                 o_M0_BRESP,
  output logic                       o_M0_BVALID,
  input  logic                       i_M0_BREADY,
  input  logic [p_ADDRESS_WIDTH-1:0] i_M0_ARADDR,
  input  logic                       i_M0_ARPROT,
  input  logic                       i_M0_ARVALID,
  output logic                       o_M0_ARREADY,
  output logic [p_DATA_WIDTH-1:0]    o_M0_RDATA,
  output logic                       o_M0_RVALID,
  input  logic                       i_M0_RREADY,
  // master 1
  input  logic [p_ADDRESS_WIDTH-1:0] i_M1_AWADDR,
  input  logic                       i_M1_AWPROT,
  input  logic                       i_M1_AWVALID,
  output logic                       o_M1_AWREADY,
  input  logic [p_DATA_WIDTH-1:0]    i_M1_WDATA,
  input  logic [lp_STROBE_WIDTH-1:0] i_M1_WSTRB,
  input  logic                       i_M1_WVALID,
  output logic                       o_M1_WREADY,
  output logic [1:0]                 o_M1_BRESP,
  output logic                       o_M1_BVALID,
  input  logic                       i_M1_BREADY,
  input  logic [p_ADDRESS_WIDTH-1:0] i_M1_ARADDR,
  input  logic                       i_M1_ARPROT,
  input  logic                       i_M1_ARVALID,
  output logic                       o_M1_ARREADY,
  output logic [p_DATA_WIDTH-1:0]    o_M1_RDATA,
  output logic                       o_M1_RVALID,
  input  logic                       i_M1_RREADY,
  // slave
  output logic [p_ADDRESS_WIDTH-1:0] o_S_AWADDR,
  output logic                       o_S_AWPROT,
  output logic                       o_S_AWVALID,
  input  logic                       i_S_AWREADY,
  output logic [p_DATA_WIDTH-1:0]    o_S_WDATA,
  output logic [lp_STROBE_WIDTH-1:0] o_S_WSTRB,
  output logic                       o_S_WVALID,
  input  logic                       i_S_WREADY,
  input  logic [1:0]                 i_S_BRESP,
  input  logic                       i_S_BVALID,
  output logic                       o_S_BREADY,
  output logic [p_ADDRESS_WIDTH-1:0] o_S_ARADDR,
  output logic                       o_S_ARPROT,
  output logic                       o_S_ARVALID,
  input  logic                       i_S_ARREADY,
  input  logic [p_DATA_WIDTH-1:0]    i_S_RDATA,
  input  logic                       i_S_RVALID,
  output logic                       o_S_RREADY,
  output logic [1:0]                 o_GRANT
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic [1:0] grant_q, grant_d;
`ifndef ARB_FIXED_PRIORITY_EN
  logic       last_owner_q, last_owner_d;
`endif

  logic req0, req1, winner;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Owner's request-side signals, muxed once for all channels
  logic [p_ADDRESS_WIDTH-1:0] sel_awaddr, sel_araddr;
  logic [p_DATA_WIDTH-1:0]    sel_wdata;
  logic [lp_STROBE_WIDTH-1:0] sel_wstrb;
  logic sel_awprot, sel_awvalid, sel_wvalid, sel_bready;
  logic sel_arprot, sel_arvalid, sel_rready;

  assign sel_awaddr  = owner_q ? i_M1_AWADDR  : i_M0_AWADDR;
  assign sel_awprot  = owner_q ? i_M1_AWPROT  : i_M0_AWPROT;
  assign sel_awvalid = owner_q ? i_M1_AWVALID : i_M0_AWVALID;
  assign sel_wdata   = owner_q ? i_M1_WDATA   : i_M0_WDATA;
  assign sel_wstrb   = owner_q ? i_M1_WSTRB   : i_M0_WSTRB;
  assign sel_wvalid  = owner_q ? i_M1_WVALID  : i_M0_WVALID;
  assign sel_bready  = owner_q ? i_M1_BREADY  : i_M0_BREADY;
  assign sel_araddr  = owner_q ? i_M1_ARADDR  : i_M0_ARADDR;
  assign sel_arprot  = owner_q ? i_M1_ARPROT  : i_M0_ARPROT;
  assign sel_arvalid = owner_q ? i_M1_ARVALID : i_M0_ARVALID;
  assign sel_rready  = owner_q ? i_M1_RREADY  : i_M0_RREADY;

  assign req0 = i_M0_AWVALID | i_M0_ARVALID;
  assign req1 = i_M1_AWVALID | i_M1_ARVALID;

`ifdef ARB_FIXED_PRIORITY_EN
  assign winner = !req0;
`else
  // Contention goes to whoever did not own the bus last
  assign winner = (req0 && req1) ? !last_owner_q : req1;
`endif

  assign aw_hs = (state_q == WR_ADDR_DATA) && sel_awvalid && !aw_done_q && i_S_AWREADY;
  assign w_hs  = (state_q == WR_ADDR_DATA) && sel_wvalid && !w_done_q && i_S_WREADY;
  assign b_hs  = (state_q == WR_RESP) && i_S_BVALID && sel_bready;
  assign ar_hs = (state_q == RD_ADDR) && sel_arvalid && i_S_ARREADY;
  assign r_hs  = (state_q == RD_DATA) && i_S_RVALID && sel_rready;

  assign o_GRANT = grant_q;

  // State and ownership registers
  always_ff @(posedge i_ACLK) begin
    if (!i_ARESETN) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      grant_q      <= 2'b00;
`ifndef ARB_FIXED_PRIORITY_EN
      last_owner_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      grant_q      <= grant_d;
`ifndef ARB_FIXED_PRIORITY_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  // Next state and channel routing
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    grant_d      = grant_q;
`ifndef ARB_FIXED_PRIORITY_EN
    last_owner_d = last_owner_q;
`endif

    o_M0_AWREADY = 1'b0;
    o_M0_WREADY  = 1'b0;
    o_M0_BRESP   = 2'b00;
    o_M0_BVALID  = 1'b0;
    o_M0_ARREADY = 1'b0;
    o_M0_RDATA   = '0;
    o_M0_RVALID  = 1'b0;
    o_M1_AWREADY = 1'b0;
    o_M1_WREADY  = 1'b0;
    o_M1_BRESP   = 2'b00;
    o_M1_BVALID  = 1'b0;
    o_M1_ARREADY = 1'b0;
    o_M1_RDATA   = '0;
    o_M1_RVALID  = 1'b0;
    o_S_AWADDR   = '0;
    o_S_AWPROT   = 1'b0;
    o_S_AWVALID  = 1'b0;
    o_S_WDATA    = '0;
    o_S_WSTRB    = '0;
    o_S_WVALID   = 1'b0;
    o_S_BREADY   = 1'b0;
    o_S_ARADDR   = '0;
    o_S_ARPROT   = 1'b0;
    o_S_ARVALID  = 1'b0;
    o_S_RREADY   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d = winner;
          grant_d = winner ? 2'b10 : 2'b01;
          // A master holding both AW and AR gets its write first
          state_d = (winner ? i_M1_AWVALID : i_M0_AWVALID) ? WR_ADDR_DATA : RD_ADDR;
        end
      end

      WR_ADDR_DATA: begin
        o_S_AWADDR  = sel_awaddr;
        o_S_AWPROT  = sel_awprot;
        o_S_AWVALID = sel_awvalid && !aw_done_q;
        o_S_WDATA   = sel_wdata;
        o_S_WSTRB   = sel_wstrb;
        o_S_WVALID  = sel_wvalid && !w_done_q;
        if (owner_q) begin
          o_M1_AWREADY = i_S_AWREADY && !aw_done_q;
          o_M1_WREADY  = i_S_WREADY && !w_done_q;
        end else begin
          o_M0_AWREADY = i_S_AWREADY && !aw_done_q;
          o_M0_WREADY  = i_S_WREADY && !w_done_q;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q || aw_hs;
          w_done_d  = w_done_q || w_hs;
        end
      end

      WR_RESP: begin
        o_S_BREADY = sel_bready;
        if (owner_q) begin
          o_M1_BVALID = i_S_BVALID;
          o_M1_BRESP  = i_S_BRESP;
        end else begin
          o_M0_BVALID = i_S_BVALID;
          o_M0_BRESP  = i_S_BRESP;
        end
        if (b_hs) begin
          state_d      = IDLE;
          grant_d      = 2'b00;
`ifndef ARB_FIXED_PRIORITY_EN
          last_owner_d = owner_q;
`endif
        end
      end

      RD_ADDR: begin
        o_S_ARADDR  = sel_araddr;
        o_S_ARPROT  = sel_arprot;
        o_S_ARVALID = sel_arvalid;
        if (owner_q) o_M1_ARREADY = i_S_ARREADY;
        else         o_M0_ARREADY = i_S_ARREADY;
        if (ar_hs) state_d = RD_DATA;
      end

      RD_DATA: begin
        o_S_RREADY = sel_rready;
        if (owner_q) begin
          o_M1_RVALID = i_S_RVALID;
          o_M1_RDATA  = i_S_RDATA;
        end else begin
          o_M0_RVALID = i_S_RVALID;
          o_M0_RDATA  = i_S_RDATA;
        end
        if (r_hs) begin
          state_d      = IDLE;
          grant_d      = 2'b00;
`ifndef ARB_FIXED_PRIORITY_EN
          last_owner_d = owner_q;
`endif
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_2to1_arbiter.sv
// Bench for axi4_lite_2to1_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the masters, the slave and the arbitration rule.
module tb_axi4_lite_2to1_arbiter;
  localparam int unsigned AW = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 1;

  logic i_ACLK = 1'b0;
  logic i_ARESETN;
  always #5 i_ACLK = ~i_ACLK;

  logic [AW-1:0] m_awaddr [2];
  logic [AW-1:0] m_araddr [2];
  logic [DW-1:0] m_wdata  [2];
  logic [SW-1:0] m_wstrb  [2];
  logic [1:0] m_awprot, m_awvalid, m_wvalid, m_bready, m_arprot, m_arvalid, m_rready;
  wire  [1:0] d_awready, d_wready, d_bvalid, d_arready, d_rvalid;
  wire  [1:0] d_bresp [2];
  wire  [DW-1:0] d_rdata [2];

  wire  [AW-1:0] o_S_AWADDR, o_S_ARADDR;
  wire  [DW-1:0] o_S_WDATA;
  wire  [SW-1:0] o_S_WSTRB;
  wire  o_S_AWPROT, o_S_AWVALID, o_S_WVALID, o_S_BREADY, o_S_ARPROT, o_S_ARVALID, o_S_RREADY;
  wire  [1:0] o_GRANT;
  logic i_S_AWREADY, i_S_WREADY, i_S_BVALID, i_S_ARREADY, i_S_RVALID;
  logic [1:0] i_S_BRESP;
  logic [DW-1:0] i_S_RDATA;

  axi4_lite_2to1_arbiter #(.p_ADDRESS_WIDTH(AW), .p_DATA_WIDTH(DW)) dut (
    .i_ACLK(i_ACLK), .i_ARESETN(i_ARESETN),
    .i_M0_AWADDR(m_awaddr[0]), .i_M0_AWPROT(m_awprot[0]), .i_M0_AWVALID(m_awvalid[0]), .o_M0_AWREADY(d_awready[0]),
    .i_M0_WDATA(m_wdata[0]), .i_M0_WSTRB(m_wstrb[0]), .i_M0_WVALID(m_wvalid[0]), .o_M0_WREADY(d_wready[0]),
    .o_M0_BRESP(d_bresp[0]), .o_M0_BVALID(d_bvalid[0]), .i_M0_BREADY(m_bready[0]),
    .i_M0_ARADDR(m_araddr[0]), .i_M0_ARPROT(m_arprot[0]), .i_M0_ARVALID(m_arvalid[0]), .o_M0_ARREADY(d_arready[0]),
    .o_M0_RDATA(d_rdata[0]), .o_M0_RVALID(d_rvalid[0]), .i_M0_RREADY(m_rready[0]),
    .i_M1_AWADDR(m_awaddr[1]), .i_M1_AWPROT(m_awprot[1]), .i_M1_AWVALID(m_awvalid[1]), .o_M1_AWREADY(d_awready[1]),
    .i_M1_WDATA(m_wdata[1]), .i_M1_WSTRB(m_wstrb[1]), .i_M1_WVALID(m_wvalid[1]), .o_M1_WREADY(d_wready[1]),
    .o_M1_BRESP(d_bresp[1]), .o_M1_BVALID(d_bvalid[1]), .i_M1_BREADY(m_bready[1]),
    .i_M1_ARADDR(m_araddr[1]), .i_M1_ARPROT(m_arprot[1]), .i_M1_ARVALID(m_arvalid[1]), .o_M1_ARREADY(d_arready[1]),
    .o_M1_RDATA(d_rdata[1]), .o_M1_RVALID(d_rvalid[1]), .i_M1_RREADY(m_rready[1]),
    .o_S_AWADDR(o_S_AWADDR), .o_S_AWPROT(o_S_AWPROT), .o_S_AWVALID(o_S_AWVALID), .i_S_AWREADY(i_S_AWREADY),
    .o_S_WDATA(o_S_WDATA), .o_S_WSTRB(o_S_WSTRB), .o_S_WVALID(o_S_WVALID), .i_S_WREADY(i_S_WREADY),
    .i_S_BRESP(i_S_BRESP), .i_S_BVALID(i_S_BVALID), .o_S_BREADY(o_S_BREADY),
    .o_S_ARADDR(o_S_ARADDR), .o_S_ARPROT(o_S_ARPROT), .o_S_ARVALID(o_S_ARVALID), .i_S_ARREADY(i_S_ARREADY),
    .i_S_RDATA(i_S_RDATA), .i_S_RVALID(i_S_RVALID), .o_S_RREADY(o_S_RREADY),
    .o_GRANT(o_GRANT)
  );

  int tests = 0;
  int fails = 0;

  // Master-side transaction state
  logic [1:0] wr_act, aw_pend, w_pend, rd_act, ar_pend, wr_prot, rd_prot;
  logic [AW-1:0] wr_addr [2];
  logic [AW-1:0] rd_addr [2];
  logic [DW-1:0] wr_data [2];
  logic [SW-1:0] wr_strb [2];
  // Slave model
  logic s_aw_got, s_w_got, s_bvalid, s_ar_got, s_rvalid;
  logic [1:0] s_bresp;
  logic [DW-1:0] s_rdata;
  // Arbitration model
  logic [1:0] exp_grant;
  logic exp_last;
  int cur_owner;
  logic cur_write;
  // Stimulus controls
  logic rnd_start, rnd_ready, force_rst, hold_b;
  int w_hold;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_wr(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic p);
    wr_act[n] = 1'b1; aw_pend[n] = 1'b1; w_pend[n] = 1'b1;
    wr_addr[n] = a; wr_data[n] = d; wr_strb[n] = s; wr_prot[n] = p;
  endtask

  task automatic start_rd(input int n, input logic [AW-1:0] a, input logic p);
    rd_act[n] = 1'b1; ar_pend[n] = 1'b1; rd_addr[n] = a; rd_prot[n] = p;
  endtask

  task automatic clear_model();
    wr_act = '0; aw_pend = '0; w_pend = '0; rd_act = '0; ar_pend = '0;
    s_aw_got = 0; s_w_got = 0; s_bvalid = 0; s_ar_got = 0; s_rvalid = 0;
    exp_grant = 2'b00; exp_last = 1'b1; cur_owner = -1; cur_write = 1'b0;
  endtask

  function automatic logic rnd_bit(input logic enable, input int unsigned odds);
    return enable ? ($urandom_range(odds) != 0) : 1'b1;
  endfunction

  // One clock of stimulus, checking and model update
  task automatic cycle();
    logic [1:0] e_aw, e_w, e_b, e_ar, e_r, rq, wq;
    logic se_aw, se_w, se_b, se_ar, se_r, rst, w;
    int o, nn;
    for (int n = 0; n < 2; n++) begin
      if (rnd_start && !wr_act[n] && $urandom_range(3) == 0)
        start_wr(n, AW'($urandom), DW'($urandom), SW'($urandom), 1'($urandom));
      if (rnd_start && !rd_act[n] && $urandom_range(3) == 0)
        start_rd(n, AW'($urandom), 1'($urandom));
      m_awvalid[n] = aw_pend[n]; m_awaddr[n] = wr_addr[n]; m_awprot[n] = wr_prot[n];
      m_wvalid[n]  = w_pend[n];  m_wdata[n]  = wr_data[n]; m_wstrb[n]  = wr_strb[n];
      m_arvalid[n] = ar_pend[n]; m_araddr[n] = rd_addr[n]; m_arprot[n] = rd_prot[n];
      m_bready[n]  = hold_b ? 1'b0 : rnd_bit(rnd_ready, 3);
      m_rready[n]  = rnd_bit(rnd_ready, 3);
    end
    i_S_AWREADY = rnd_bit(rnd_ready, 2);
    i_S_WREADY  = (w_hold > 0) ? 1'b0 : rnd_bit(rnd_ready, 2);
    if (w_hold > 0) w_hold--;
    i_S_ARREADY = rnd_bit(rnd_ready, 2);
    if (s_aw_got && s_w_got && !s_bvalid && rnd_bit(rnd_ready, 1)) begin
      s_bvalid = 1'b1; s_bresp = 2'($urandom);
    end
    if (s_ar_got && !s_rvalid && rnd_bit(rnd_ready, 1)) begin
      s_rvalid = 1'b1; s_rdata = DW'($urandom);
    end
    i_S_BVALID = s_bvalid; i_S_BRESP = s_bvalid ? s_bresp : 2'b00;
    i_S_RVALID = s_rvalid; i_S_RDATA = s_rvalid ? s_rdata : '0;
    i_ARESETN  = !force_rst;
    #1;

    chk("grant", 64'(o_GRANT), 64'(exp_grant));
    if (cur_owner < 0) begin
      chk("idle_slave", 64'({o_S_AWVALID, o_S_WVALID, o_S_ARVALID, o_S_BREADY, o_S_RREADY}), 0);
      chk("idle_master", 64'({d_awready, d_wready, d_arready, d_bvalid, d_rvalid}), 0);
    end else begin
      o = cur_owner; nn = 1 - o;
      chk("nonowner", 64'({d_awready[nn], d_wready[nn], d_arready[nn], d_bvalid[nn], d_rvalid[nn]}), 0);
      if (cur_write) begin
        chk("wr_no_read", 64'({o_S_ARVALID, o_S_RREADY, d_arready[o], d_rvalid[o]}), 0);
        if (!(s_aw_got && s_w_got)) begin
          chk("s_awvalid", 64'(o_S_AWVALID), 64'(aw_pend[o]));
          chk("s_wvalid", 64'(o_S_WVALID), 64'(w_pend[o]));
          if (aw_pend[o]) begin
            chk("s_aw", 64'({o_S_AWPROT, o_S_AWADDR}), 64'({wr_prot[o], wr_addr[o]}));
            chk("m_awready", 64'(d_awready[o]), 64'(i_S_AWREADY));
          end
          if (w_pend[o]) begin
            chk("s_w", 64'({o_S_WSTRB, o_S_WDATA}), 64'({wr_strb[o], wr_data[o]}));
            chk("m_wready", 64'(d_wready[o]), 64'(i_S_WREADY));
          end
          chk("early_b", 64'({d_bvalid[o], o_S_BREADY}), 0);
        end else begin
          chk("resp_no_aw_w", 64'({o_S_AWVALID, o_S_WVALID}), 0);
          chk("m_bvalid", 64'(d_bvalid[o]), 64'(s_bvalid));
          if (s_bvalid) chk("m_bresp", 64'(d_bresp[o]), 64'(s_bresp));
          chk("s_bready", 64'(o_S_BREADY), 64'(m_bready[o]));
        end
      end else begin
        chk("rd_no_write", 64'({o_S_AWVALID, o_S_WVALID, o_S_BREADY, d_awready[o], d_wready[o], d_bvalid[o]}), 0);
        if (!s_ar_got) begin
          chk("s_arvalid", 64'(o_S_ARVALID), 64'(ar_pend[o]));
          chk("s_ar", 64'({o_S_ARPROT, o_S_ARADDR}), 64'({rd_prot[o], rd_addr[o]}));
          chk("m_arready", 64'(d_arready[o]), 64'(i_S_ARREADY));
          chk("early_r", 64'({d_rvalid[o], o_S_RREADY}), 0);
        end else begin
          chk("data_no_ar", 64'(o_S_ARVALID), 0);
          chk("m_rvalid", 64'(d_rvalid[o]), 64'(s_rvalid));
          if (s_rvalid) chk("m_rdata", 64'(d_rdata[o]), 64'(s_rdata));
          chk("s_rready", 64'(o_S_RREADY), 64'(m_rready[o]));
        end
      end
    end

    e_aw = m_awvalid & d_awready; e_w = m_wvalid & d_wready; e_ar = m_arvalid & d_arready;
    e_b  = d_bvalid & m_bready;   e_r = d_rvalid & m_rready;
    se_aw = o_S_AWVALID & i_S_AWREADY; se_w = o_S_WVALID & i_S_WREADY;
    se_ar = o_S_ARVALID & i_S_ARREADY; se_b = i_S_BVALID & o_S_BREADY; se_r = i_S_RVALID & o_S_RREADY;
    for (int n = 0; n < 2; n++)
      if (e_b[n]) chk("b_after_aw_w", 64'({aw_pend[n], w_pend[n]}), 0);
    if (e_b != 0 || se_b) chk("b_one", 64'(e_b), 64'({1'b0, se_b} << (cur_owner < 0 ? 0 : cur_owner)));
    rq = m_awvalid | m_arvalid; wq = m_awvalid; rst = force_rst;

    @(posedge i_ACLK); #1;
    if (rst) begin
      clear_model();
    end else begin
      aw_pend &= ~e_aw; w_pend &= ~e_w; wr_act &= ~e_b; ar_pend &= ~e_ar; rd_act &= ~e_r;
      if (se_aw) s_aw_got = 1'b1;
      if (se_w)  s_w_got  = 1'b1;
      if (se_ar) s_ar_got = 1'b1;
      if (se_b) begin s_aw_got = 0; s_w_got = 0; s_bvalid = 0; end
      if (se_r) begin s_ar_got = 0; s_rvalid = 0; end
      if (se_b || se_r) begin
        exp_grant = 2'b00; exp_last = cur_owner[0]; cur_owner = -1;
      end else if (cur_owner < 0 && rq != 2'b00) begin
`ifdef ARB_FIXED_PRIORITY_EN
        w = !rq[0];
`else
        w = (rq == 2'b11) ? !exp_last : rq[1];
`endif
        cur_owner = int'(w); cur_write = wq[w]; exp_grant = w ? 2'b10 : 2'b01;
      end
    end
  endtask

  task automatic drain(input int max_cycles);
    int i;
    rnd_start = 1'b0;
    i = 0;
    while ((wr_act != 0 || rd_act != 0 || cur_owner >= 0) && i < max_cycles) begin
      cycle(); i++;
    end
    chk("drain_done", 64'({wr_act, rd_act, cur_owner >= 0}), 0);
  endtask

  task automatic do_reset();
    m_awvalid = '0; m_wvalid = '0; m_arvalid = '0; m_bready = '0; m_rready = '0;
    m_awprot = '0; m_arprot = '0;
    for (int n = 0; n < 2; n++) begin
      m_awaddr[n] = '0; m_araddr[n] = '0; m_wdata[n] = '0; m_wstrb[n] = '0;
      wr_addr[n] = '0; rd_addr[n] = '0; wr_data[n] = '0; wr_strb[n] = '0;
    end
    wr_prot = '0; rd_prot = '0;
    i_S_AWREADY = 0; i_S_WREADY = 0; i_S_ARREADY = 0; i_S_BVALID = 0; i_S_RVALID = 0;
    i_S_BRESP = '0; i_S_RDATA = '0; s_bresp = '0; s_rdata = '0;
    clear_model();
    i_ARESETN = 1'b0;
    repeat (2) @(posedge i_ACLK);
    #1;
    chk("rst_grant", 64'(o_GRANT), 0);
    chk("rst_ctrl", 64'({o_S_AWVALID, o_S_WVALID, o_S_ARVALID, o_S_BREADY, o_S_RREADY,
                         d_awready, d_wready, d_arready, d_bvalid, d_rvalid}), 0);
    chk("rst_data", 64'({o_S_AWADDR, o_S_WDATA, o_S_WSTRB, o_S_ARADDR, o_S_AWPROT, o_S_ARPROT,
                         d_rdata[0], d_rdata[1], d_bresp[0], d_bresp[1]}), 0);
    i_ARESETN = 1'b1;
  endtask

  initial begin
    int i;
    rnd_start = 0; rnd_ready = 0; force_rst = 0; hold_b = 0; w_hold = 0;
    do_reset();

    // Single M0 write
    start_wr(0, 2'd2, 8'hA5, 1'b1, 1'b0);
    drain(20);

    // Simultaneous reads after reset: M0 first
    do_reset();
    start_rd(0, 2'd1, 1'b0);
    start_rd(1, 2'd3, 1'b1);
    drain(30);

    // Repeated simultaneous writes
    for (int k = 0; k < 4; k++) begin
      start_wr(0, AW'(k), DW'(8'h10 + k), 1'b1, 1'b0);
      start_wr(1, AW'(3 - k), DW'(8'h20 + k), 1'b1, 1'b1);
      drain(40);
    end

    // AW accepted while slave holds WREADY low
    start_wr(1, 2'd1, 8'h3C, 1'b1, 1'b0);
    w_hold = 3;
    drain(30);

    // Write and read raised together on one master
    start_wr(0, 2'd3, 8'h5A, 1'b0, 1'b1);
    start_rd(0, 2'd2, 1'b0);
    drain(30);

    // Random traffic
    rnd_start = 1; rnd_ready = 1;
    for (int k = 0; k < 3000; k++) cycle();
    drain(400);

    // Reset while in write response with slave BVALID high
    rnd_ready = 0; hold_b = 1;
    start_wr(0, 2'd1, 8'h77, 1'b1, 1'b0);
    i = 0;
    while (!(s_aw_got && s_w_got) && i < 20) begin cycle(); i++; end
    chk("reach_wr_resp", 64'({s_aw_got, s_w_got}), 64'(2'b11));
    force_rst = 1;
    cycle();
    chk("rst_mid_grant", 64'(o_GRANT), 0);
    chk("rst_mid_valids", 64'({d_bvalid, d_rvalid, o_S_AWVALID, o_S_WVALID, o_S_ARVALID,
                               o_S_BREADY, o_S_RREADY}), 0);
    force_rst = 0; hold_b = 0;
    start_wr(1, 2'd0, 8'hC3, 1'b1, 1'b1);
    drain(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi4_lite_2to1_arbiter.md
Name: axi4_lite_2to1_arbiter

Overview:
- Shares one AXI4-Lite slave (e.g. the basic register slave) between two AXI4-Lite masters, M0 and M1.
- Serialises whole transactions: one write (AW+W+B) or one read (AR+R) is in flight at a time.
- Round-robin grant between masters. Sits between the interconnect masters and the slave port.

Parameters:
- p_ADDRESS_WIDTH, 2, AW/AR address width on all ports.
- p_DATA_WIDTH, 8, W/R data width on all ports.
- lp_STROBE_WIDTH (local), (p_DATA_WIDTH>=8 ? p_DATA_WIDTH/8 : 1), WSTRB width.

Ports:
- i_ACLK  in  1  single clock; all logic on rising edge.
- i_ARESETN  in  1  synchronous, active-low reset.
- Master side, per master n in {0,1}:
  - i_Mn_AWADDR in p_ADDRESS_WIDTH; i_Mn_AWPROT in 1; i_Mn_AWVALID in 1; o_Mn_AWREADY out 1.
  - i_Mn_WDATA in p_DATA_WIDTH; i_Mn_WSTRB in lp_STROBE_WIDTH; i_Mn_WVALID in 1; o_Mn_WREADY out 1.
  - o_Mn_BRESP out 2; o_Mn_BVALID out 1; i_Mn_BREADY in 1.
  - i_Mn_ARADDR in p_ADDRESS_WIDTH; i_Mn_ARPROT in 1; i_Mn_ARVALID in 1; o_Mn_ARREADY out 1.
  - o_Mn_RDATA out p_DATA_WIDTH; o_Mn_RVALID out 1; i_Mn_RREADY in 1.
- Slave side: the same signal set with o_S_/i_S_ prefixes and directions reversed.
- o_GRANT  out  2  one-hot current owner (bit0=M0, bit1=M1); 0 when idle.

Behaviour:
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA. Registers: state, owner (1 bit), last_owner (1 bit), aw_done, w_done.
- Reset (i_ARESETN==0 at a clock edge): state=IDLE, o_GRANT=0, last_owner=1 (so M0 wins first), aw_done=w_done=0.
- Reset outputs: all o_S_*VALID, o_S_BREADY, o_S_RREADY and all o_Mn_*READY/*VALID are 0. Data and response outputs are 0.
- Request from master n: req_n = AWVALID | ARVALID. If a master asserts both, its write is taken first.
- IDLE, single requester: grant it.
- IDLE, both requesting: grant the master != last_owner. Fixed priority applies instead when the optional feature is compiled in.
- Grant is registered: one cycle of arbitration latency. State moves to WR_ADDR_DATA or RD_ADDR on the edge after the request is seen. No channel is forwarded during the IDLE cycle.
- WR_ADDR_DATA:
  - AW and W of the owner pass combinationally to the slave; slave AWREADY/WREADY pass back to the owner only.
  - The non-owner's readies are held 0.
  - aw_done and w_done set on their handshakes, which may occur in the same cycle or in either order.
  - After its handshake, o_S_AWVALID (resp. o_S_WVALID) is masked to 0.
  - When both are done: go to WR_RESP and clear the flags.
- WR_RESP: slave BVALID/BRESP route to the owner, owner BREADY routes to the slave. On B handshake: go to IDLE and set last_owner=owner.
- RD_ADDR: owner AR passes to the slave; on AR handshake go to RD_DATA.
- RD_DATA: R channel routes to the owner; on R handshake go to IDLE and set last_owner=owner.
- Non-owner's BVALID/RVALID are always 0. Slave responses outside WR_RESP/RD_DATA are ignored, with o_S_BREADY=o_S_RREADY=0.
- A master dropping VALID before handshake is a protocol violation; no recovery is required.
- Reset mid-transaction returns to IDLE on that edge and drops all valids. The slave must be reset by the same i_ARESETN.
- Throughput: at most one transaction per 3 cycles (IDLE + address + response minimum).
- o_GRANT is one-hot of owner in every non-IDLE state.

Optional Feature:
- Macro ARB_FIXED_PRIORITY_EN.
- Defined: M0 always wins when both request in IDLE; last_owner is unused and may be optimised away.
- Undefined (default): round-robin as above.

Test Plan:
- Reset then M0 write AWADDR=2, WDATA=0xA5, slave BRESP=0 → o_GRANT=01 one cycle after request; slave sees AWADDR=2/WDATA=0xA5; o_M0_BVALID=1 with BRESP=0; o_M1_* readies stay 0.
- Both masters read in the same cycle after reset (M0 ARADDR=1, M1 ARADDR=3) → M0 served first, then M1; slave sees ARADDR 1 then 3; each o_Mn_RDATA matches the slave RDATA of its own transaction.
- Repeated simultaneous writes → grants alternate 01,10,01,10. With ARB_FIXED_PRIORITY_EN defined → grants are always 01 while M0 keeps requesting.
- AW handshake 2 cycles before W (slave WREADY delayed) → o_S_AWVALID drops after the AW handshake; state enters WR_RESP only after the W handshake; exactly one B is returned.
- i_ARESETN=0 asserted in WR_RESP with slave BVALID=1 → next cycle o_GRANT=0, all master valids 0, state IDLE; the next M1 request is granted normally.
- Master asserts AWVALID+WVALID and ARVALID together → write completes fully (B handshake) before the AR is forwarded.
